bsg_link_sdr_credit_downstream_array: RTL and testbench

// - Multi-channel, single-clock receive endpoint for credit-flow-controlled SDR links.
// - Buffers num_channels_p independent valid/data streams and returns credits upstream as toggling tokens, with decimation.
// - Link signals are already synchronous to clk_i; the block sits between the link PHY and the core.
// - Successor to the single-channel SDR downstream: multi-channel array, single clock domain, with optional overflow detection.
//

---
 rtl/bsg_link_sdr_credit_downstream_array.sv | 109 ++++++++++
 tb/tb_bsg_link_sdr_credit_downstream_array.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_link_sdr_credit_downstream_array.sv
// Multi-channel single-clock receive endpoint for credit-flow-controlled SDR links.
// Optional sticky overflow detection is enabled by defining BSG_LINK_SDR_CREDIT_DS_OVERFLOW_CHECK_EN.
module bsg_link_sdr_credit_downstream_array #(
    parameter int width_p                         = 8,
    parameter int num_channels_p                  = 2,
    parameter int lg_fifo_depth_p                 = 3,
    parameter int lg_credit_to_token_decimation_p = 0
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_channels_p-1:0]         link_v_i,
    input  logic [num_channels_p*width_p-1:0] link_data_i,
    output logic [num_channels_p-1:0]         link_token_r_o,
    output logic [num_channels_p-1:0]         core_v_o,
    output logic [num_channels_p*width_p-1:0] core_data_o,
    input  logic [num_channels_p-1:0]         core_yumi_i,
    output logic [num_channels_p-1:0]         overflow_o
);

    localparam int depth_lp = 1 << lg_fifo_depth_p;
    localparam int ptr_w_lp = lg_fifo_depth_p + 1;
    localparam int cnt_w_lp = lg_credit_to_token_decimation_p + 1;
    localparam logic [ptr_w_lp-1:0] depth_cnt_lp = ptr_w_lp'(depth_lp);
    localparam logic [cnt_w_lp-1:0] token_period_lp =
        cnt_w_lp'(1) << lg_credit_to_token_decimation_p;

    for (genvar c = 0; c < num_channels_p; c++) begin : ch
        logic [width_p-1:0]         mem [depth_lp];
        logic [ptr_w_lp-1:0]        wptr;
        logic [ptr_w_lp-1:0]        rptr;
        logic [lg_fifo_depth_p-1:0] waddr;
        logic [lg_fifo_depth_p-1:0] raddr;
        logic [cnt_w_lp-1:0]        credit_cnt;
        logic [cnt_w_lp-1:0]        credit_cnt_inc;
        logic                       token_r;
        logic                       full;
        logic                       empty;
        logic                       enq;
        logic                       deq;

        // Pointers carry one extra wrap bit so full and empty stay distinct.
        assign waddr          = wptr[lg_fifo_depth_p-1:0];
        assign raddr          = rptr[lg_fifo_depth_p-1:0];
        assign empty          = (wptr == rptr);
        assign full           = ((wptr - rptr) == depth_cnt_lp);
        assign enq            = link_v_i[c] & ~full;
        assign deq            = core_yumi_i[c] & ~empty;
        assign credit_cnt_inc = credit_cnt + cnt_w_lp'(1);

        always_ff @(posedge clk_i) begin
            if (enq) begin
                mem[waddr] <= link_data_i[c*width_p +: width_p];
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                wptr       <= '0;
                rptr       <= '0;
                credit_cnt <= '0;
                token_r    <= 1'b0;
            end else begin
                if (enq) begin
                    wptr <= wptr + ptr_w_lp'(1);
                end
                if (deq) begin
                    rptr <= rptr + ptr_w_lp'(1);
                    // Each token edge stands for 2**D returned credits.
                    if (credit_cnt_inc == token_period_lp) begin
                        credit_cnt <= '0;
                        token_r    <= ~token_r;
                    end else begin
                        credit_cnt <= credit_cnt_inc;
                    end
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!reset_i) begin
                assert (!(core_yumi_i[c] && empty))
                    else $error("channel %0d: yumi while empty at %0t", c, $time);
            end
        end

        assign core_v_o[c]                      = ~empty;
        assign core_data_o[c*width_p +: width_p] = mem[raddr];
        assign link_token_r_o[c]                = token_r;

`ifdef BSG_LINK_SDR_CREDIT_DS_OVERFLOW_CHECK_EN
        logic overflow_r;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                overflow_r <= 1'b0;
            end else if (link_v_i[c] && full) begin
                overflow_r <= 1'b1;
                assert (overflow_r)
                    else $error("channel %0d: overflow, word dropped at %0t", c, $time);
            end
        end

        assign overflow_o[c] = overflow_r;
`else
        assign overflow_o[c] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_bsg_link_sdr_credit_downstream_array.sv
// Bench for bsg_link_sdr_credit_downstream_array: one instance with D=0, one with D=2,
// checked every cycle against a queue-based reference model plus directed vectors.
module tb_bsg_link_sdr_credit_downstream_array;

    localparam int W     = 8;
    localparam int N     = 2;
    localparam int LG    = 3;
    localparam int DEPTH = 1 << LG;
`ifdef BSG_LINK_SDR_CREDIT_DS_OVERFLOW_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        bit           v;
        byte unsigned d;
        bit           y;
        bit           ev;
        byte unsigned ed;
        bit           et;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   link_v    [2];
    logic [N-1:0]   yumi      [2];
    logic [N-1:0]   token     [2];
    logic [N-1:0]   core_v    [2];
    logic [N-1:0]   ovf       [2];
    logic [N*W-1:0] link_data [2];
    logic [N*W-1:0] core_data [2];

    int checks = 0;
    int errors = 0;

    // Reference model, index k = instance*2 + channel.
    byte unsigned mq [4][$];
    int unsigned  dcnt [4];
    bit           movf [4];
    int           cred [4];
    logic         last_tok [4];

    always #5 clk = ~clk;

    bsg_link_sdr_credit_downstream_array #(
        .width_p(W), .num_channels_p(N), .lg_fifo_depth_p(LG),
        .lg_credit_to_token_decimation_p(0)
    ) dut_d0 (
        .clk_i(clk), .reset_i(reset),
        .link_v_i(link_v[0]), .link_data_i(link_data[0]),
        .link_token_r_o(token[0]), .core_v_o(core_v[0]),
        .core_data_o(core_data[0]), .core_yumi_i(yumi[0]),
        .overflow_o(ovf[0])
    );

    bsg_link_sdr_credit_downstream_array #(
        .width_p(W), .num_channels_p(N), .lg_fifo_depth_p(LG),
        .lg_credit_to_token_decimation_p(2)
    ) dut_d2 (
        .clk_i(clk), .reset_i(reset),
        .link_v_i(link_v[1]), .link_data_i(link_data[1]),
        .link_token_r_o(token[1]), .core_v_o(core_v[1]),
        .core_data_o(core_data[1]), .core_yumi_i(yumi[1]),
        .overflow_o(ovf[1])
    );

    function automatic int dec(int k);
        return (k < 2) ? 0 : 2;
    endfunction

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic set_in(int inst, int c, bit v, byte unsigned d, bit y);
        link_v[inst][c]          = v;
        link_data[inst][c*W +: W] = d;
        yumi[inst][c]            = y;
    endtask

    task automatic clear_in();
        for (int i = 0; i < 2; i++) begin
            link_v[i]    = '0;
            yumi[i]      = '0;
            link_data[i] = '0;
        end
    endtask

    // Advance one clock: the model consumes the inputs seen at the edge,
    // then every output of every channel is compared #1 later.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            int inst = k / 2;
            int c    = k % 2;
            bit full;
            if (reset) begin
                mq[k].delete();
                dcnt[k] = 0;
                movf[k] = 1'b0;
            end else begin
                full = (mq[k].size() == DEPTH);
                if (link_v[inst][c] && full) movf[k] = 1'b1;
                if (yumi[inst][c] && mq[k].size() > 0) begin
                    void'(mq[k].pop_front());
                    dcnt[k]++;
                end
                if (link_v[inst][c] && !full) mq[k].push_back(link_data[inst][c*W +: W]);
            end
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            int inst = k / 2;
            int c    = k % 2;
            chk("model_v", k, 32'(core_v[inst][c]), 32'(mq[k].size() > 0));
            if (mq[k].size() > 0)
                chk("model_data", k, 32'(core_data[inst][c*W +: W]), 32'(mq[k][0]));
            chk("model_token", k, 32'(token[inst][c]), 32'((dcnt[k] >> dec(k)) & 1));
            chk("model_ovf", k, 32'(ovf[inst][c]), 32'(OVF_EN & movf[k]));
        end
    endtask

    initial begin
        vec_t tbl [6];
        tbl[0] = '{v:0, d:8'h00, y:0, ev:0, ed:8'h00, et:0};
        tbl[1] = '{v:1, d:8'hA5, y:0, ev:1, ed:8'hA5, et:0};
        tbl[2] = '{v:0, d:8'h00, y:1, ev:0, ed:8'h00, et:1};
        tbl[3] = '{v:1, d:8'h3C, y:0, ev:1, ed:8'h3C, et:1};
        tbl[4] = '{v:1, d:8'h5A, y:1, ev:1, ed:8'h5A, et:0};
        tbl[5] = '{v:0, d:8'h00, y:1, ev:0, ed:8'h00, et:1};

        clear_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 2; i++) begin
            chk("reset_core_v", i, 32'(core_v[i]), 32'd0);
            chk("reset_token", i, 32'(token[i]), 32'd0);
            chk("reset_ovf", i, 32'(ovf[i]), 32'd0);
        end

        // D=0 directed vectors on instance 0 channel 0
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, tbl[i].v, tbl[i].d, tbl[i].y);
            tick();
            chk("tbl_v", i, 32'(core_v[0][0]), 32'(tbl[i].ev));
            if (tbl[i].ev) chk("tbl_data", i, 32'(core_data[0][W-1:0]), 32'(tbl[i].ed));
            chk("tbl_token", i, 32'(token[0][0]), 32'(tbl[i].et));
        end
        clear_in();

        // D=2 on instance 1 channel 1: fill 8, drain 8, token toggles after 4th and 8th
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 1, 1'b1, byte'(8'h10 + i), 1'b0);
            tick();
        end
        clear_in();
        for (int i = 0; i < DEPTH; i++) begin
            chk("d2_head_v", i, 32'(core_v[1][1]), 32'd1);
            chk("d2_head_data", i, 32'(core_data[1][2*W-1:W]), 32'(8'h10 + i));
            set_in(1, 1, 1'b0, 8'h00, 1'b1);
            tick();
            chk("d2_token", i, 32'(token[1][1]), 32'(((i + 1) / 4) % 2));
        end
        clear_in();
        tick();
        chk("d2_empty", 3, 32'(core_v[1][1]), 32'd0);

        // Overflow on instance 0 channel 0: fill, then a 9th word with same-cycle yumi
        for (int i = 0; i < DEPTH; i++) begin
            set_in(0, 0, 1'b1, byte'(8'h40 + i), 1'b0);
            tick();
        end
        set_in(0, 0, 1'b1, 8'hEE, 1'b1);
        tick();
        chk("ovf_set", 0, 32'(ovf[0][0]), 32'(OVF_EN));
        clear_in();
        for (int i = 0; i < DEPTH - 1; i++) begin
            chk("ovf_drain_v", i, 32'(core_v[0][0]), 32'd1);
            chk("ovf_drain_data", i, 32'(core_data[0][W-1:0]), 32'(8'h41 + i));
            set_in(0, 0, 1'b0, 8'h00, 1'b1);
            tick();
        end
        clear_in();
        chk("ovf_occupancy7", 0, 32'(core_v[0][0]), 32'd0);
        tick();
        chk("ovf_sticky", 0, 32'(ovf[0][0]), 32'(OVF_EN));

        // Mid-operation reset with 5 words held on instance 0 channel 0
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 1'b1, byte'(8'h60 + i), 1'b0);
            tick();
        end
        clear_in();
        chk("pre_reset_token", 0, 32'(token[0][0]), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_reset_v", 0, 32'(core_v[0][0]), 32'd0);
        chk("mid_reset_token", 0, 32'(token[0][0]), 32'd0);
        chk("mid_reset_ovf", 0, 32'(ovf[0][0]), 32'd0);
        set_in(0, 0, 1'b1, 8'h3C, 1'b0);
        tick();
        clear_in();
        chk("post_reset_v", 0, 32'(core_v[0][0]), 32'd1);
        chk("post_reset_data", 0, 32'(core_data[0][W-1:0]), 32'h3C);

        // Random credit-respecting traffic on all four channels
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cred[k]     = DEPTH;
            last_tok[k] = 1'b0;
        end
        repeat (10000) begin
            for (int k = 0; k < 4; k++) begin
                bit sv;
                bit sy;
                sv = (cred[k] > 0) && ($urandom_range(3) != 0);
                sy = (mq[k].size() > 0) && ($urandom_range(2) != 0);
                set_in(k / 2, k % 2, sv, byte'($urandom), sy);
                if (sv) cred[k]--;
            end
            tick();
            for (int k = 0; k < 4; k++) begin
                if (token[k / 2][k % 2] !== last_tok[k]) begin
                    cred[k]     += 1 << dec(k);
                    last_tok[k]  = token[k / 2][k % 2];
                end
            end
        end
        clear_in();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
